// File: rtl/host_mat_responder.sv
// Host-side matrix-load responder: 4-phase ready/valid handshake with an asynchronous
// host, storing each byte into weight memory. Define HOST_PARITY_EN for odd-parity checking.
module host_mat_responder #(
    parameter int DATA_W    = 8,
    parameter int NUM_ELEMS = 8,
    parameter int ADDR_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_req_mat,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_valid,
`ifdef HOST_PARITY_EN
    input  logic              host_parity,
    output logic              parity_err,
`endif
    output logic              host_ready,
    output logic              wm_we,
    output logic [ADDR_W-1:0] wm_addr,
    output logic [DATA_W-1:0] wm_wdata,
    output logic              busy,
    output logic              load_done
);

    // state        | meaning
    // IDLE         | no request; counter and address held at 0
    // WAIT_VALID   | host_ready high, waiting for synchronised valid
    // WAIT_RELEASE | element captured (or rejected), waiting for valid to fall
    // DONE         | all elements stored, waiting for the request to drop
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_VALID   = 2'd1,
        WAIT_RELEASE = 2'd2,
        DONE         = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_ELEMS - 1);

    if ((2 ** ADDR_W) < NUM_ELEMS) begin : g_addr_check
        $error("ADDR_W too narrow for NUM_ELEMS");
    end

    state_t            state;
    logic [ADDR_W-1:0] count;
    logic              v_meta;
    logic              vs;
    logic              retry;
    logic              par_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_meta <= 1'b0;
            vs     <= 1'b0;
        end else begin
            v_meta <= host_valid;
            vs     <= v_meta;
        end
    end

`ifdef HOST_PARITY_EN
    assign par_ok = ^{host_data, host_parity};
`else
    assign par_ok = 1'b1;
`endif

    // All outputs are registered; each transition sets them for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            retry      <= 1'b0;
            host_ready <= 1'b0;
            wm_we      <= 1'b0;
            wm_addr    <= '0;
            wm_wdata   <= '0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
`ifdef HOST_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            wm_we     <= 1'b0;
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    host_ready <= 1'b0;
                    busy       <= 1'b0;
                    count      <= '0;
                    wm_addr    <= '0;
                    retry      <= 1'b0;
                    if (host_req_mat) begin
                        state      <= WAIT_VALID;
                        host_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                WAIT_VALID: begin
                    if (!host_req_mat) begin
                        state      <= IDLE;
                        host_ready <= 1'b0;
                        busy       <= 1'b0;
                        count      <= '0;
`ifdef HOST_PARITY_EN
                        parity_err <= 1'b0;
`endif
                    end else if (vs) begin
                        state      <= WAIT_RELEASE;
                        host_ready <= 1'b0;
                        retry      <= !par_ok;
                        if (par_ok) begin
                            wm_we    <= 1'b1;
                            wm_wdata <= host_data;
                            wm_addr  <= count;
                        end
`ifdef HOST_PARITY_EN
                        else begin
                            parity_err <= 1'b1;
                        end
`endif
                    end
                end

                WAIT_RELEASE: begin
                    if (!host_req_mat) begin
                        state      <= IDLE;
                        host_ready <= 1'b0;
                        busy       <= 1'b0;
                        count      <= '0;
`ifdef HOST_PARITY_EN
                        parity_err <= 1'b0;
`endif
                    end else if (!vs) begin
                        // A rejected element returns to the same address for retransmission.
                        if (!retry && count == LAST) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                        end else begin
                            state      <= WAIT_VALID;
                            host_ready <= 1'b1;
                            if (!retry) begin
                                count <= count + 1'b1;
                            end
                        end
                    end
                end

                DONE: begin
                    host_ready <= 1'b0;
                    if (!host_req_mat) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        count <= '0;
`ifdef HOST_PARITY_EN
                        parity_err <= 1'b0;
`endif
                    end
                end

                default: begin
                    state      <= IDLE;
                    host_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_mat_responder.sv
// Directed bench for host_mat_responder: normal load, latency, long valid, abort,
// mid-load reset, done hold, and (with HOST_PARITY_EN) parity retransmission.
module tb_host_mat_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_req_mat = 1'b0;
    logic [7:0] host_data = 8'h00;
    logic       host_valid = 1'b0;
`ifdef HOST_PARITY_EN
    logic       host_parity = 1'b0;
    logic       parity_err;
`endif
    logic       host_ready;
    logic       wm_we;
    logic [2:0] wm_addr;
    logic [7:0] wm_wdata;
    logic       busy;
    logic       load_done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int wr_addr[$];
    int wr_data[$];
    int base;
    int dbase;

    always #5 clk = ~clk;

    host_mat_responder #(.DATA_W(8), .NUM_ELEMS(8), .ADDR_W(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .host_req_mat(host_req_mat),
        .host_data(host_data),
        .host_valid(host_valid),
`ifdef HOST_PARITY_EN
        .host_parity(host_parity),
        .parity_err(parity_err),
`endif
        .host_ready(host_ready),
        .wm_we(wm_we),
        .wm_addr(wm_addr),
        .wm_wdata(wm_wdata),
        .busy(busy),
        .load_done(load_done)
    );

    always @(negedge clk) begin
        if (wm_we === 1'b1) begin
            wr_addr.push_back(int'(wm_addr));
            wr_data.push_back(int'(wm_wdata));
        end
        if (load_done === 1'b1) done_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input logic lvl, input string tag);
        int n = 0;
        @(negedge clk);
        while (host_ready !== lvl && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(host_ready), 32'(lvl));
    endtask

    task automatic send_elem(input logic [7:0] d);
        wait_ready(1'b1, "ready_high");
        host_data = d;
`ifdef HOST_PARITY_EN
        host_parity = ~(^d);
`endif
        host_valid = 1'b1;
        wait_ready(1'b0, "ready_low");
        host_valid = 1'b0;
    endtask

    task automatic chk_wr(input int idx, input int a, input int d);
        chk($sformatf("wr%0d_addr", idx), 32'(wr_addr.size() > idx ? wr_addr[idx] : -1), 32'(a));
        chk($sformatf("wr%0d_data", idx), 32'(wr_data.size() > idx ? wr_data[idx] : -1), 32'(d));
    endtask

    initial begin
        // reset state
        settle(3);
        chk("rst_ready", 32'(host_ready), 32'd0);
        chk("rst_we", 32'(wm_we), 32'd0);
        chk("rst_addr", 32'(wm_addr), 32'd0);
        chk("rst_wdata", 32'(wm_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // normal load with latency check on the first element
        @(negedge clk);
        host_req_mat = 1'b1;
        settle(1);
        chk("busy_after_req", 32'(busy), 32'd1);
        chk("ready_after_req", 32'(host_ready), 32'd1);
        @(negedge clk);
        host_data = 8'h11;
`ifdef HOST_PARITY_EN
        host_parity = ~(^host_data);
`endif
        host_valid = 1'b1;
        settle(1);
        chk("lat_edge_k", 32'(wm_we), 32'd0);
        settle(1);
        chk("lat_edge_k1", 32'(wm_we), 32'd0);
        settle(1);
        chk("lat_edge_k2_we", 32'(wm_we), 32'd1);
        chk("lat_edge_k2_addr", 32'(wm_addr), 32'd0);
        chk("lat_edge_k2_data", 32'(wm_wdata), 32'h11);
        chk("lat_edge_k2_ready", 32'(host_ready), 32'd0);
        @(negedge clk);
        host_valid = 1'b0;
        for (int i = 2; i <= 8; i++) send_elem(8'(i * 8'h11));
        settle(8);
        chk("norm_writes", 32'(wr_addr.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk_wr(i, i, (i + 1) * 8'h11);
        chk("norm_done_cnt", 32'(done_cnt), 32'd1);
        chk("norm_busy_held", 32'(busy), 32'd1);
        chk("norm_ready_done", 32'(host_ready), 32'd0);
        chk("norm_addr_hold", 32'(wm_addr), 32'd7);
        @(negedge clk);
        host_req_mat = 1'b0;
        settle(3);
        chk("norm_idle_busy", 32'(busy), 32'd0);
        chk("norm_idle_addr", 32'(wm_addr), 32'd0);

        // long valid, then abort after the third element
        base = wr_addr.size();
        @(negedge clk);
        host_req_mat = 1'b1;
        wait_ready(1'b1, "long_ready_high");
        host_data = 8'h5A;
`ifdef HOST_PARITY_EN
        host_parity = ~(^host_data);
`endif
        host_valid = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("long_ready_low", 32'(host_ready), 32'd0);
        chk("long_one_write", 32'(wr_addr.size() - base), 32'd1);
        host_valid = 1'b0;
        wait_ready(1'b1, "long_release");
        #1;
        chk("long_still_one", 32'(wr_addr.size() - base), 32'd1);
        send_elem(8'h01);
        send_elem(8'h02);
        host_req_mat = 1'b0;
        settle(6);
        chk("abort_writes", 32'(wr_addr.size() - base), 32'd3);
        chk_wr(base, 0, 8'h5A);
        chk_wr(base + 1, 1, 8'h01);
        chk_wr(base + 2, 2, 8'h02);
        chk("abort_no_done", 32'(done_cnt), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(host_ready), 32'd0);
        chk("abort_addr", 32'(wm_addr), 32'd0);

        // restart at address 0, then reset during WAIT_RELEASE of element 5
        base = wr_addr.size();
        @(negedge clk);
        host_req_mat = 1'b1;
        for (int i = 0; i < 5; i++) send_elem(8'(8'hA0 + i));
        rst_n = 1'b0;
        #1;
        chk("mrst_we", 32'(wm_we), 32'd0);
        chk("mrst_addr", 32'(wm_addr), 32'd0);
        chk("mrst_wdata", 32'(wm_wdata), 32'd0);
        chk("mrst_ready", 32'(host_ready), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(load_done), 32'd0);
        chk_wr(base, 0, 8'hA0);
        chk_wr(base + 4, 4, 8'hA4);
        repeat (2) @(negedge clk);
        host_req_mat = 1'b0;
        rst_n = 1'b1;
        settle(2);
        chk("mrst_idle_busy", 32'(busy), 32'd0);

        // full load after reset, then hold request in DONE and toggle valid
        base = wr_addr.size();
        dbase = done_cnt;
        @(negedge clk);
        host_req_mat = 1'b1;
        for (int i = 1; i <= 8; i++) send_elem(8'(i * 8'h11));
        settle(8);
        chk("reload_writes", 32'(wr_addr.size() - base), 32'd8);
        chk_wr(base, 0, 8'h11);
        chk_wr(base + 7, 7, 8'h88);
        chk("reload_done", 32'(done_cnt - dbase), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            host_data = 8'hEE;
            host_valid = 1'b1;
            repeat (5) @(negedge clk);
            #1;
            chk("hold_ready", 32'(host_ready), 32'd0);
            host_valid = 1'b0;
            repeat (5) @(negedge clk);
        end
        settle(2);
        chk("hold_no_write", 32'(wr_addr.size() - base), 32'd8);
        chk("hold_no_done", 32'(done_cnt - dbase), 32'd1);
        chk("hold_busy", 32'(busy), 32'd1);
        @(negedge clk);
        host_req_mat = 1'b0;
        settle(3);
        chk("hold_idle_busy", 32'(busy), 32'd0);

`ifdef HOST_PARITY_EN
        // bad parity on element 2, then retransmit
        base = wr_addr.size();
        dbase = done_cnt;
        chk("par_clear", 32'(parity_err), 32'd0);
        @(negedge clk);
        host_req_mat = 1'b1;
        send_elem(8'h01);
        send_elem(8'h02);
        wait_ready(1'b1, "par_bad_ready");
        host_data = 8'h03;
        host_parity = ^host_data;
        host_valid = 1'b1;
        wait_ready(1'b0, "par_bad_capture");
        host_valid = 1'b0;
        settle(1);
        chk("par_err_set", 32'(parity_err), 32'd1);
        chk("par_no_write", 32'(wr_addr.size() - base), 32'd2);
        send_elem(8'h03);
        for (int i = 4; i <= 8; i++) send_elem(8'(i));
        settle(8);
        chk("par_writes", 32'(wr_addr.size() - base), 32'd8);
        chk_wr(base + 2, 2, 8'h03);
        chk_wr(base + 7, 7, 8'h08);
        chk("par_done", 32'(done_cnt - dbase), 32'd1);
        chk("par_err_sticky", 32'(parity_err), 32'd1);
        @(negedge clk);
        host_req_mat = 1'b0;
        settle(3);
        chk("par_err_idle", 32'(parity_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
